pwm_channel_bank: RTL and testbench

//  Multi-channel PWM waveform generator. Consumes the per-channel config strobes from the
//  PWM parameter parser (channel index, enable, period/high-level counts in clk cycles).

---
 rtl/pwm_channel_bank_pkg.sv | 9 +
 rtl/pwm_channel_bank_if.sv | 20 ++
 rtl/pwm_channel_bank_channel.sv | 73 +++++++
 rtl/pwm_channel_bank.sv | 51 +++++
 tb/tb_pwm_channel_bank.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_channel_bank_pkg.sv
// Shared constants for the PWM bank and the upstream parameter parser.
package pwm_channel_bank_pkg;

  localparam int PWM_CNT_W    = 28;
  localparam int PWM_CH_IDX_W = 8;

  typedef logic [PWM_CH_IDX_W-1:0] pwm_ch_idx_t;

endpackage

// File: rtl/pwm_channel_bank_if.sv
// Config strobe bundle from the parameter parser into the PWM bank.
interface pwm_channel_bank_if #(
  parameter int CNT_W = pwm_channel_bank_pkg::PWM_CNT_W
);

  logic                                    pwm_config_vld;
  logic [pwm_channel_bank_pkg::PWM_CH_IDX_W-1:0] pwm_config_channel;
  logic                                    pwm_en;
  logic [CNT_W-1:0]                        pwm_period;
  logic [CNT_W-1:0]                        pwm_hlevel;

  modport master (
    output pwm_config_vld, pwm_config_channel, pwm_en, pwm_period, pwm_hlevel
  );

  modport slave (
    input pwm_config_vld, pwm_config_channel, pwm_en, pwm_period, pwm_hlevel
  );

endinterface

// File: rtl/pwm_channel_bank_channel.sv
// One PWM channel: pending/active settings, period counter and output flop.
// Pending settings move to active when the channel is idle, on a stop request,
// or on the last count of the running period, so the waveform never carries
// a partial period into the new settings.
module pwm_channel #(
  parameter int CNT_W = pwm_channel_bank_pkg::PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] hlevel,
  output logic             pwm_out,
  output logic             pwm_active
);

  logic             pend_flag;
  logic             pend_en;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_hlevel;
  logic             act_en;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_hlevel;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             load;

  // Last count of the period, and when pending settings take over.
  always_comb begin
    wrap = (cnt == act_period - 1'b1);
    load = pend_flag && (!act_en || !pend_en || wrap);
  end

  // Pending/active registers, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_flag   <= 1'b0;
      pend_en     <= 1'b0;
      pend_period <= '0;
      pend_hlevel <= '0;
      act_en      <= 1'b0;
      act_period  <= '0;
      act_hlevel  <= '0;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      pwm_active  <= 1'b0;
    end else begin
      // A write on the swap edge lands in pending and waits for the next boundary.
      if (wr) begin
        pend_flag   <= 1'b1;
        pend_en     <= en;
        pend_period <= period;
        pend_hlevel <= hlevel;
      end else if (load) begin
        pend_flag <= 1'b0;
      end

      if (load) begin
        act_en     <= pend_en && (pend_period != '0);
        act_period <= pend_period;
        act_hlevel <= pend_hlevel;
        cnt        <= '0;
      end else if (act_en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end

      pwm_out    <= act_en && (cnt < act_hlevel);
      pwm_active <= act_en;
    end
  end

endmodule

// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM bank: decodes config strobes onto its channel range and
// flags strobes aimed at channels it does not own.
module pwm_channel_bank
  import pwm_channel_bank_pkg::*;
#(
  parameter int CH_NUM  = 8,
  parameter int CH_BASE = 0,
  parameter int CNT_W   = PWM_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  pwm_channel_bank_if.slave   cfg,
  output logic [CH_NUM-1:0]   pwm_out,
  output logic [CH_NUM-1:0]   pwm_active,
  output logic                cfg_err
);

  logic              in_range;
  logic [CH_NUM-1:0] wr_stb;

  // Channel index decode into one write strobe per owned channel.
  always_comb begin
    in_range = (int'(cfg.pwm_config_channel) >= CH_BASE) &&
               (int'(cfg.pwm_config_channel) < CH_BASE + CH_NUM);
    wr_stb   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg.pwm_config_vld && (int'(cfg.pwm_config_channel) == CH_BASE + i))
        wr_stb[i] = 1'b1;
    end
  end

  // One-cycle error pulse for strobes outside this bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg.pwm_config_vld && !in_range;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_stb[g]),
      .en         (cfg.pwm_en),
      .period     (cfg.pwm_period),
      .hlevel     (cfg.pwm_hlevel),
      .pwm_out    (pwm_out[g]),
      .pwm_active (pwm_active[g])
    );
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank (CH_NUM=8, CH_BASE=0).
// Outputs are sampled 1 time unit after the rising edge.
module tb_pwm_channel_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pwm_out;
  logic [7:0] pwm_active;
  logic       cfg_err;
  int         n_assert = 0;
  int         n_fail   = 0;

  pwm_channel_bank_if #(.CNT_W(28)) cfg_if ();

  pwm_channel_bank #(.CH_NUM(8), .CH_BASE(0), .CNT_W(28)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if),
    .pwm_out    (pwm_out),
    .pwm_active (pwm_active),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe is sampled on the next rising edge; returns 1 unit after that edge.
  task automatic cfg(input int ch, input logic en, input int per, input int hl);
    cfg_if.pwm_config_vld     = 1'b1;
    cfg_if.pwm_config_channel = 8'(ch);
    cfg_if.pwm_en             = en;
    cfg_if.pwm_period         = 28'(per);
    cfg_if.pwm_hlevel         = 28'(hl);
    @(posedge clk);
    #1;
    cfg_if.pwm_config_vld     = 1'b0;
  endtask

  initial begin
    cfg_if.pwm_config_vld     = 1'b0;
    cfg_if.pwm_config_channel = '0;
    cfg_if.pwm_en             = 1'b0;
    cfg_if.pwm_period         = '0;
    cfg_if.pwm_hlevel         = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(pwm_out), 32'h0);
    chk("rst_active", 32'(pwm_active), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    rst = 1'b0;
    step();

    // 1: ch0 10/3 from idle, rises 2 clk after strobe
    cfg(0, 1'b1, 10, 3);
    chk("t1_edgeT", 32'(pwm_out[0]), 32'h0);
    step();
    chk("t1_edgeT1_out", 32'(pwm_out[0]), 32'h0);
    chk("t1_edgeT1_act", 32'(pwm_active[0]), 32'h0);
    for (int k = 0; k < 25; k++) begin
      step();
      chk("t1_wave", 32'(pwm_out[0]), 32'((k % 10) < 3));
      chk("t1_active", 32'(pwm_active[0]), 32'h1);
    end

    // 2: mid-period hlevel change, current period finishes with old setting
    cfg(0, 1'b1, 10, 7);
    chk("t2_ph5", 32'(pwm_out[0]), 32'h0);
    for (int k = 6; k < 10; k++) begin
      step();
      chk("t2_tail", 32'(pwm_out[0]), 32'h0);
    end
    for (int k = 0; k < 19; k++) begin
      step();
      chk("t2_new", 32'(pwm_out[0]), 32'((k % 10) < 7));
    end
    // strobe on the boundary edge: one more period of 7-high, then 2-high
    cfg(0, 1'b1, 10, 2);
    chk("t2_bnd", 32'(pwm_out[0]), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_keep7", 32'(pwm_out[0]), 32'(k < 7));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_hl2", 32'(pwm_out[0]), 32'(k < 2));
    end

    // 3: ch1 hlevel extremes and period 0
    cfg(1, 1'b1, 10, 0);
    step();
    step();
    chk("t3_hl0_act", 32'(pwm_active[1]), 32'h1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hl0_out", 32'(pwm_out[1]), 32'h0);
    end
    cfg(1, 1'b1, 10, 10);
    repeat (12) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hl10_out", 32'(pwm_out[1]), 32'h1);
    end
    cfg(1, 1'b1, 10, 15);
    repeat (12) step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hl15_out", 32'(pwm_out[1]), 32'h1);
    end
    cfg(1, 1'b1, 0, 5);
    repeat (12) step();
    chk("t3_p0_out", 32'(pwm_out[1]), 32'h0);
    chk("t3_p0_act", 32'(pwm_active[1]), 32'h0);

    // 4: ch2 stopped mid-high; ch3 constant high stays untouched
    cfg(3, 1'b1, 5, 9);
    repeat (3) step();
    chk("t4_ch3_on", 32'(pwm_out[3]), 32'h1);
    cfg(2, 1'b1, 8, 4);
    step();
    step();
    chk("t4_ch2_first", 32'(pwm_out[2]), 32'h1);
    chk("t4_ch2_act", 32'(pwm_active[2]), 32'h1);
    cfg(2, 1'b0, 0, 0);
    chk("t4_stop_T", 32'(pwm_out[2]), 32'h1);
    step();
    chk("t4_stop_T1_out", 32'(pwm_out[2]), 32'h1);
    chk("t4_stop_T1_act", 32'(pwm_active[2]), 32'h1);
    step();
    chk("t4_stop_T2_out", 32'(pwm_out[2]), 32'h0);
    chk("t4_stop_T2_act", 32'(pwm_active[2]), 32'h0);
    chk("t4_ch3_out", 32'(pwm_out[3]), 32'h1);
    chk("t4_others_act", 32'(pwm_active), 32'h09);
    repeat (10) step();
    chk("t4_ch2_stays", 32'(pwm_out[2]), 32'h0);

    // 5: out-of-bank strobes
    chk("t5_err_idle", 32'(cfg_err), 32'h0);
    cfg(8, 1'b1, 10, 3);
    chk("t5_err8", 32'(cfg_err), 32'h1);
    step();
    chk("t5_err8_off", 32'(cfg_err), 32'h0);
    cfg(255, 1'b0, 0, 0);
    chk("t5_err255", 32'(cfg_err), 32'h1);
    step();
    chk("t5_err255_off", 32'(cfg_err), 32'h0);
    repeat (12) step();
    chk("t5_act", 32'(pwm_active), 32'h09);
    chk("t5_hi_out", 32'(pwm_out[7:4]), 32'h0);
    chk("t5_ch3_out", 32'(pwm_out[3]), 32'h1);

    // 6: async reset during high phase, no resume after release
    @(posedge clk);
    #2;
    chk("t6_pre", 32'(pwm_out[3]), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 32'(pwm_out), 32'h0);
    chk("t6_rst_act", 32'(pwm_active), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) step();
    chk("t6_post_out", 32'(pwm_out), 32'h0);
    chk("t6_post_act", 32'(pwm_active), 32'h0);
    chk("t6_post_err", 32'(cfg_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
